// File: rtl/krnl_cam_pkg.sv
// krnl_cam_pkg: shared state codes and header field positions for the CAM kernel
package krnl_cam_pkg;
    localparam int ST_W    = 3;
    localparam int OPC_LSB = 0;
    localparam int CNT_LSB = 32;
    localparam int CNT_MSB = 61;
    localparam int IDX_LSB = 64;

    typedef enum logic [ST_W-1:0] {
        IDLE       = 3'd0,
        UPDATE_ALL = 3'd1,
        SEARCH     = 3'd2,
        UPDATE_ONE = 3'd3
    } state_t;

    function automatic logic is_data(state_t s);
        return s != IDLE;
    endfunction
endpackage

// File: rtl/krnl_cam_rtl_seq_if.sv
// krnl_cam_rtl_seq_if: input stream plus CAM-side payload/write bus of the sequencer
interface krnl_cam_rtl_seq_if #(
    parameter int C_DATA_WIDTH = 520,
    parameter int AW           = 7
);
    logic [C_DATA_WIDTH-1:0] s_tdata;
    logic                    s_tvalid;
    logic                    s_tready;
    logic [C_DATA_WIDTH-1:0] m_tdata;
    logic                    m_tvalid;
    logic                    m_tready;
    logic                    m_we;
    logic [AW-1:0]           m_waddr;
    logic                    m_last;

    modport master (
        output s_tdata, s_tvalid, m_tready,
        input  s_tready, m_tdata, m_tvalid, m_we, m_waddr, m_last
    );
    modport slave (
        input  s_tdata, s_tvalid, m_tready,
        output s_tready, m_tdata, m_tvalid, m_we, m_waddr, m_last
    );
endinterface

// File: rtl/krnl_cam_rtl_hdr_decode.sv
// krnl_cam_rtl_hdr_decode: combinational header check yielding next state, count and index
module krnl_cam_rtl_hdr_decode
    import krnl_cam_pkg::*;
#(
    parameter int C_DATA_WIDTH = 520,
    parameter int CAM_SIZE     = 128,
    parameter int CNT_WIDTH    = 30,
    localparam int AW          = $clog2(CAM_SIZE)
) (
    input  logic [C_DATA_WIDTH-1:0] hdr,
    output logic                    valid,
    output logic                    err,
    output state_t                  nxt,
    output logic [CNT_WIDTH-1:0]    cnt,
    output logic [AW-1:0]           idx
);
    logic [ST_W-1:0]      opc;
    logic [CNT_WIDTH-1:0] n;
    logic                 unused_bits;

    assign unused_bits = ^hdr;

    always_comb begin
        opc   = hdr[OPC_LSB +: ST_W];
        n     = hdr[CNT_LSB +: CNT_WIDTH];
        valid = (opc == UPDATE_ONE) || ((opc == UPDATE_ALL || opc == SEARCH) && n != '0);
        err   = !valid;
        nxt   = valid ? state_t'(opc) : IDLE;
        // UPDATE_ONE always carries exactly one payload word regardless of N
        cnt   = (opc == UPDATE_ONE) ? CNT_WIDTH'(1) : n;
        idx   = hdr[IDX_LSB +: AW];
    end
endmodule

// File: rtl/krnl_cam_rtl_seq.sv
// krnl_cam_rtl_seq: parses stream headers and steers payload to the CAM as writes or search keys
module krnl_cam_rtl_seq
    import krnl_cam_pkg::*;
#(
    parameter int C_DATA_WIDTH  = 520,
    parameter int CAM_SIZE      = 128,
    parameter int OP_CODE_WIDTH = 3,
    parameter int CNT_WIDTH     = 30,
    localparam int AW           = $clog2(CAM_SIZE)
) (
    input  logic                     aclk,
    input  logic                     areset,
    krnl_cam_rtl_seq_if.slave        bus,
    output logic [OP_CODE_WIDTH-1:0] state,
    output logic [OP_CODE_WIDTH-1:0] state_pulse,
    output logic                     update_all_end,
    output logic                     search_end,
    output logic [15:0]              err_cnt
);
    state_t               st, st_d, pulse_q, dec_nxt;
    logic [CNT_WIDTH-1:0] rem, ptr, dec_cnt;
    logic [AW-1:0]        idx_q, dec_idx;
    logic                 dec_valid, dec_err, uae_q, se_q;
    logic                 idle, drop, hs, hdr_ok, hdr_bad, pay, fin;

    krnl_cam_rtl_hdr_decode #(
        .C_DATA_WIDTH(C_DATA_WIDTH),
        .CAM_SIZE    (CAM_SIZE),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_dec (
        .hdr  (bus.s_tdata),
        .valid(dec_valid),
        .err  (dec_err),
        .nxt  (dec_nxt),
        .cnt  (dec_cnt),
        .idx  (dec_idx)
    );

    always_comb begin
        idle         = !is_data(st);
        // UPDATE_ALL words past the last CAM entry are swallowed locally
        drop         = st == UPDATE_ALL && ptr >= CNT_WIDTH'(CAM_SIZE);
        bus.s_tready = idle || drop || bus.m_tready;
        bus.m_tvalid = !idle && !drop && bus.s_tvalid;
        bus.m_tdata  = bus.s_tdata;
        bus.m_we     = st == UPDATE_ALL || st == UPDATE_ONE;
        bus.m_waddr  = st == UPDATE_ALL ? ptr[AW-1:0] : st == UPDATE_ONE ? idx_q : '0;
        bus.m_last   = !idle && rem == CNT_WIDTH'(1);
        hs           = bus.s_tvalid && bus.s_tready;
        hdr_ok       = idle && hs && dec_valid;
        hdr_bad      = idle && hs && dec_err;
        pay          = !idle && hs;
        fin          = pay && rem == CNT_WIDTH'(1);
        st_d         = hdr_ok ? dec_nxt : fin ? IDLE : st;
    end

    always_ff @(posedge aclk) begin
        if (areset) st <= IDLE;
        else        st <= st_d;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            pulse_q <= IDLE;
            rem     <= '0;
            ptr     <= '0;
            idx_q   <= '0;
            uae_q   <= 1'b0;
            se_q    <= 1'b0;
            err_cnt <= '0;
        end else begin
            pulse_q <= hdr_ok ? dec_nxt : IDLE;
            uae_q   <= fin && st == UPDATE_ALL;
            se_q    <= fin && st == SEARCH;
            if (hdr_ok) begin
                rem   <= dec_cnt;
                ptr   <= '0;
                idx_q <= dec_idx;
            end else if (pay) begin
                rem <= rem - CNT_WIDTH'(1);
                ptr <= ptr + CNT_WIDTH'(1);
            end
            if (hdr_bad && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end
    end

    assign state          = OP_CODE_WIDTH'(st);
    assign state_pulse    = OP_CODE_WIDTH'(pulse_q);
    assign update_all_end = uae_q;
    assign search_end     = se_q;
endmodule

// File: tb/tb_krnl_cam_rtl_seq.sv
// tb_krnl_cam_rtl_seq: directed stimulus with a cycle-level reference model and literal checkpoints
module tb_krnl_cam_rtl_seq;
    localparam int DW = 520;
    localparam int AW = 7;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [2:0]  state, state_pulse;
    logic        update_all_end, search_end;
    logic [15:0] err_cnt;

    krnl_cam_rtl_seq_if #(.C_DATA_WIDTH(DW), .AW(AW)) bus();

    krnl_cam_rtl_seq dut (
        .aclk          (aclk),
        .areset        (areset),
        .bus           (bus),
        .state         (state),
        .state_pulse   (state_pulse),
        .update_all_end(update_all_end),
        .search_end    (search_end),
        .err_cnt       (err_cnt)
    );

    always #5 aclk = ~aclk;

    int n_chk = 0, n_fail = 0;
    int wlog[$];
    int n_uae = 0, n_se = 0, n_fwd = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] hdr(input int opc, input int n, input int idx);
        logic [DW-1:0] h;
        h = '0;
        h[2:0]   = opc[2:0];
        h[61:32] = n[29:0];
        h[70:64] = idx[6:0];
        return h;
    endfunction

    function automatic logic [DW-1:0] pay(input int k);
        logic [DW-1:0] p;
        p = '0;
        for (int j = 0; j < 16; j++) p[j*32 +: 32] = k * 32'h9E3779B9 + j;
        p[519:512] = k[7:0];
        return p;
    endfunction

    task automatic send(input logic [DW-1:0] w);
        bus.s_tdata  = w;
        bus.s_tvalid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge aclk);
            if (bus.s_tready === 1'b1) begin
                @(posedge aclk);
                #1 bus.s_tvalid = 1'b0;
                return;
            end
            @(posedge aclk);
            #1;
        end
        n_chk++;
        n_fail++;
        $display("FAIL send_timeout: s_tready stayed low for 200 cycles");
        bus.s_tvalid = 1'b0;
    endtask

    // Reference model: operation-level bookkeeping of what the outputs must be
    int          m_st = 0, m_pulse = 0, m_err = 0;
    logic [29:0] m_rem = '0, m_ptr = '0;
    logic [6:0]  m_idx = '0;
    bit          m_uae = 0, m_se = 0, live = 0;

    always @(negedge aclk) begin
        bit          drop, exp_rdy, exp_val;
        logic [2:0]  opc;
        logic [29:0] n;
        drop    = m_st == 1 && m_ptr >= 30'd128;
        exp_rdy = m_st == 0 || drop || bus.m_tready;
        exp_val = m_st != 0 && !drop && bus.s_tvalid;
        if (live) begin
            check("state", DW'(state), DW'(m_st));
            check("state_pulse", DW'(state_pulse), DW'(m_pulse));
            check("update_all_end", DW'(update_all_end), DW'(m_uae));
            check("search_end", DW'(search_end), DW'(m_se));
            check("err_cnt", DW'(err_cnt), DW'(m_err));
            check("s_tready", DW'(bus.s_tready), DW'(exp_rdy));
            check("m_tvalid", DW'(bus.m_tvalid), DW'(exp_val));
            check("m_last", DW'(bus.m_last), DW'(m_st != 0 && m_rem == 30'd1));
            if (exp_val) begin
                check("m_tdata", bus.m_tdata, bus.s_tdata);
                check("m_we", DW'(bus.m_we), DW'(m_st == 1 || m_st == 3));
                check("m_waddr", DW'(bus.m_waddr),
                      m_st == 1 ? DW'(m_ptr) : m_st == 3 ? DW'(m_idx) : DW'(0));
            end
            if (update_all_end === 1'b1) n_uae++;
            if (search_end === 1'b1) n_se++;
            if (bus.m_tvalid === 1'b1 && bus.m_tready === 1'b1) begin
                n_fwd++;
                if (bus.m_we === 1'b1) wlog.push_back(int'(bus.m_waddr));
            end
        end
        if (areset) begin
            m_st = 0; m_pulse = 0; m_err = 0; m_rem = '0; m_ptr = '0; m_idx = '0;
            m_uae = 0; m_se = 0; live = 1;
        end else begin
            m_pulse = 0; m_uae = 0; m_se = 0;
            if (m_st == 0) begin
                if (bus.s_tvalid) begin
                    opc = bus.s_tdata[2:0];
                    n   = bus.s_tdata[61:32];
                    if (opc == 3) begin
                        m_st = 3; m_rem = 30'd1; m_ptr = '0; m_idx = bus.s_tdata[70:64]; m_pulse = 3;
                    end else if ((opc == 1 || opc == 2) && n != 0) begin
                        m_st = int'(opc); m_rem = n; m_ptr = '0; m_pulse = int'(opc);
                    end else if (m_err < 65535) begin
                        m_err++;
                    end
                end
            end else if (bus.s_tvalid && exp_rdy) begin
                if (m_rem == 30'd1) begin
                    m_uae = m_st == 1;
                    m_se  = m_st == 2;
                    m_st  = 0;
                end
                m_rem = m_rem - 30'd1;
                m_ptr = m_ptr + 30'd1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int se0, fwd0;
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = '0;
        bus.m_tready = 1'b1;
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        check("rst_state", DW'(state), DW'(0));
        check("rst_m_last", DW'(bus.m_last), DW'(0));
        check("rst_m_waddr", DW'(bus.m_waddr), DW'(0));

        // UPDATE_ALL N=3
        wlog.delete();
        send(hdr(1, 3, 0));
        check("ua3_pulse", DW'(state_pulse), DW'(1));
        for (int k = 0; k < 3; k++) send(pay(k));
        check("ua3_end", DW'(update_all_end), DW'(1));
        check("ua3_state", DW'(state), DW'(0));
        check("ua3_nwrites", DW'(wlog.size()), DW'(3));
        for (int k = 0; k < 3 && k < wlog.size(); k++) check("ua3_addr", DW'(wlog[k]), DW'(k));

        // SEARCH N=2 with a 5-cycle stall between the words
        wlog.delete();
        se0  = n_se;
        fwd0 = n_fwd;
        send(hdr(2, 2, 0));
        send(pay(10));
        bus.m_tready = 1'b0;
        bus.s_tdata  = pay(11);
        bus.s_tvalid = 1'b1;
        repeat (5) @(posedge aclk);
        #1 check("srch_stall_state", DW'(state), DW'(2));
        bus.m_tready = 1'b1;
        send(pay(11));
        repeat (3) @(posedge aclk);
        #1 check("srch_end_count", DW'(n_se - se0), DW'(1));
        check("srch_fwd_count", DW'(n_fwd - fwd0), DW'(2));
        check("srch_no_writes", DW'(wlog.size()), DW'(0));

        // UPDATE_ONE idx 77, then SEARCH header with no bubble
        wlog.delete();
        send(hdr(3, 9, 77));
        check("uo_pulse", DW'(state_pulse), DW'(3));
        send(pay(20));
        send(hdr(2, 1, 0));
        check("uo_srch_pulse", DW'(state_pulse), DW'(2));
        send(pay(21));
        check("uo_nwrites", DW'(wlog.size()), DW'(1));
        if (wlog.size() > 0) check("uo_addr", DW'(wlog[0]), DW'(77));

        // Rejected headers
        send(hdr(5, 4, 0));
        send(hdr(0, 4, 0));
        send(hdr(2, 0, 0));
        check("err_cnt3", DW'(err_cnt), DW'(3));
        check("err_state", DW'(state), DW'(0));

        // UPDATE_ALL N=130 overruns the 128-entry CAM
        wlog.delete();
        fwd0 = n_fwd;
        send(hdr(1, 130, 0));
        for (int k = 0; k < 130; k++) send(pay(100 + k));
        check("ua130_end", DW'(update_all_end), DW'(1));
        check("ua130_nwrites", DW'(wlog.size()), DW'(128));
        check("ua130_fwd", DW'(n_fwd - fwd0), DW'(128));
        if (wlog.size() == 128) check("ua130_last_addr", DW'(wlog[127]), DW'(127));

        // Reset mid-SEARCH with 4 words outstanding
        se0 = n_se;
        send(hdr(2, 6, 0));
        send(pay(300));
        send(pay(301));
        areset = 1'b1;
        @(posedge aclk);
        #1 areset = 1'b0;
        check("rst_mid_state", DW'(state), DW'(0));
        check("rst_mid_err", DW'(err_cnt), DW'(0));
        check("rst_mid_mlast", DW'(bus.m_last), DW'(0));
        wlog.delete();
        send(hdr(3, 0, 5));
        check("rst_hdr_state", DW'(state), DW'(3));
        send(pay(302));
        repeat (3) @(posedge aclk);
        #1 check("rst_no_se", DW'(n_se - se0), DW'(0));
        check("rst_write", DW'(wlog.size()), DW'(1));
        if (wlog.size() > 0) check("rst_write_addr", DW'(wlog[0]), DW'(5));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/krnl_cam_rtl_seq.md
# krnl_cam_rtl_seq

Operation sequencer for the CAM kernel datapath. It sits between the 520-bit input stream and the CAM adder/compare datapath. It parses header words carrying an opcode and a word count, then steers the following payload words to the CAM as writes or search keys. It also publishes the current operation state, entry pulses and end-of-operation pulses that the datapath uses to sequence itself.

## Interface
Parameters:
- C_DATA_WIDTH, 520: width of stream words.
- CAM_SIZE, 128: number of CAM entries.
- OP_CODE_WIDTH, 3: opcode/state field width.
- CNT_WIDTH, 30: payload word-count width.

Ports:
- aclk  in  1  kernel clock; single clock domain.
- areset  in  1  reset; synchronous, active-high.
- s_tdata  in  C_DATA_WIDTH  input stream word (header or payload).
- s_tvalid  in  1  input word valid.
- s_tready  out  1  input word accepted when s_tvalid & s_tready.
- m_tdata  out  C_DATA_WIDTH  payload word forwarded to CAM (equals s_tdata).
- m_tvalid  out  1  payload valid to CAM.
- m_tready  in  1  CAM accepts payload.
- m_we  out  1  qualifies m_tvalid as a CAM entry write (UPDATE_ALL/UPDATE_ONE).
- m_waddr  out  $clog2(CAM_SIZE)  CAM entry index for writes.
- m_last  out  1  final payload word of the current operation.
- state  out  OP_CODE_WIDTH  current state code.
- state_pulse  out  OP_CODE_WIDTH  new state code for the one cycle after entry; IDLE otherwise.
- update_all_end  out  1  one-cycle pulse when UPDATE_ALL completes.
- search_end  out  1  one-cycle pulse when SEARCH completes.
- err_cnt  out  16  count of rejected headers; saturates at 0xFFFF.

## Operation
- State codes: IDLE=0, UPDATE_ALL=1, SEARCH=2, UPDATE_ONE=3. Codes 4–7 are illegal.
- Header fields:
  - opcode = s_tdata[2:0].
  - N = s_tdata[61:32].
  - index = s_tdata[64 +: $clog2(CAM_SIZE)], used only by UPDATE_ONE.
- IDLE:
  - s_tready=1, m_tvalid=0. Every accepted word is a header and is never forwarded.
  - Legal opcode 1 or 2 with N≥1 → enter that state with remaining count rem=N.
  - Opcode 3 → enter UPDATE_ONE with rem=1. N is ignored.
  - Opcode 0, illegal opcode, or N=0 on opcode 1/2 → stay IDLE, err_cnt+1.
- Data states:
  - s_tready = m_tready and m_tvalid = s_tvalid, combinationally. m_tdata = s_tdata.
  - Each payload handshake decrements rem. m_last = (rem==1).
- UPDATE_ALL:
  - m_we=1, m_waddr = write pointer, starting at 0 and incrementing per handshake.
  - Payload words with pointer ≥ CAM_SIZE are consumed (s_tready=1) but not forwarded: m_tvalid=0 for them. They still decrement rem.
- UPDATE_ONE: m_we=1, m_waddr = latched header index.
- SEARCH: m_we=0, m_waddr=0.
- Last payload handshake → IDLE.
  - update_all_end pulses if leaving UPDATE_ALL; search_end pulses if leaving SEARCH.
  - No end pulse exists for UPDATE_ONE.

## Timing
- Reset values: state=IDLE, state_pulse=IDLE, m_tvalid=0, m_we=0, m_waddr=0, m_last=0, update_all_end=0, search_end=0, err_cnt=0. Also rem=0 and the write pointer cleared.
- Reset has priority over every other event. Reset mid-operation abandons the operation with no end pulse; the next accepted word is treated as a header.
- Header accepted at cycle t:
  - state updates at t+1.
  - state_pulse equals the new code during t+1 only.
  - The first payload can be accepted at t+1.
- Last payload accepted at cycle t:
  - state=IDLE at t+1.
  - The end pulse is high during t+1.
  - The next header can be accepted at t+1.
- Minimum operation is 2 cycles. Back-to-back operations have zero bubbles beyond the header cycle.
- m_tvalid must not depend on m_tready. Holding m_tready low stalls payload indefinitely with no state change.
- err_cnt updates at t+1 after the rejected header.
- rem and the pointer are registered. All CNT_WIDTH arithmetic is unsigned; rem never underflows.

## Structure
- Shared package krnl_cam_pkg holds:
  - state enum {IDLE, UPDATE_ALL, SEARCH, UPDATE_ONE}, sized OP_CODE_WIDTH;
  - header field bit positions (OPC_LSB=0, CNT_LSB=32, CNT_MSB=61, IDX_LSB=64).
- Sub-module krnl_cam_rtl_hdr_decode: combinational header decode (opcode legality, N, index → valid/err/next-state). It is reused by the host-side command checker.
- Main module: FSM, rem counter, write pointer, pulse registers, err_cnt.

## Test plan
- UPDATE_ALL, N=3, then 3 payload words with m_tready=1:
  - m_waddr = 0,1,2 with m_we=1;
  - m_last on the third word;
  - state_pulse=1 for one cycle;
  - update_all_end one cycle after the third handshake; state back to 0.
- SEARCH, N=2, with m_tready low for 5 cycles mid-stream:
  - no word is lost or duplicated;
  - m_we=0;
  - search_end pulses exactly once.
- UPDATE_ONE with index=77 and N=9, followed immediately by a SEARCH header on the next cycle:
  - one write at m_waddr=77;
  - SEARCH state_pulse arrives with no bubble.
- Headers with opcode=5, opcode=0, and SEARCH with N=0:
  - all three are rejected and err_cnt=3;
  - state stays IDLE and m_tvalid stays 0.
- UPDATE_ALL with N=130 (CAM_SIZE=128):
  - words 0–127 are forwarded;
  - words 128–129 are consumed with m_tvalid=0;
  - update_all_end follows the 130th handshake.
- areset asserted mid-SEARCH with rem=4:
  - the next cycle shows all outputs at reset values and no end pulse;
  - the following word is parsed as a header.
